// File: rtl/mod12_load_arb.sv
// Two-requester round-robin arbiter that hands a shared mod-12 load/run counter to one
// requester at a time, reporting completion and illegal load values.
module mod12_load_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic [3:0] len0,
  input  logic [3:0] len1,
  output logic [1:0] gnt,
  output logic [3:0] q,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] Q_MAX = 4'd11;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [1:0] gnt_nxt;
  logic [3:0] q_nxt;
  logic [3:0] remaining;
  logic [3:0] remaining_nxt;
  logic       err_flag;
  logic       err_flag_nxt;
  logic       last;
  logic       last_nxt;

  logic       pick1;
  logic       owner_req;
  logic [3:0] sel_in;
  logic [3:0] sel_len;
  logic [3:0] q_inc;

  // last == 1 means requester 1 was granted most recently, so a tie goes to requester 0.
  assign pick1     = req1 & (~req0 | ~last);
  assign owner_req = gnt[1] ? req1 : req0;
  assign sel_in    = gnt[1] ? in1  : in0;
  assign sel_len   = gnt[1] ? len1 : len0;
  assign q_inc     = (q == Q_MAX) ? 4'd0 : q + 4'd1;

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign err  = done & err_flag;

  always_comb begin
    state_nxt     = state;
    gnt_nxt       = gnt;
    q_nxt         = q;
    remaining_nxt = remaining;
    err_flag_nxt  = err_flag;
    last_nxt      = last;

    case (state)
      IDLE: begin
        if (req0 | req1) begin
          gnt_nxt   = pick1 ? 2'b10 : 2'b01;
          state_nxt = LOAD;
        end
      end

      LOAD: begin
        if (!owner_req) begin
          state_nxt    = IDLE;
          gnt_nxt      = 2'b00;
          err_flag_nxt = 1'b0;
        end else begin
          if (sel_in > Q_MAX) begin
            q_nxt        = 4'd0;
            err_flag_nxt = 1'b1;
          end else begin
            q_nxt        = sel_in;
            err_flag_nxt = 1'b0;
          end
          remaining_nxt = sel_len;
          // A zero-length run finishes straight away with q left at the loaded value.
          if (sel_len == 4'd0) begin
            state_nxt = DONE;
            last_nxt  = gnt[1];
          end else begin
            state_nxt = RUN;
          end
        end
      end

      RUN: begin
        if (!owner_req) begin
          state_nxt    = IDLE;
          gnt_nxt      = 2'b00;
          err_flag_nxt = 1'b0;
        end else begin
          q_nxt         = q_inc;
          remaining_nxt = remaining - 4'd1;
          if (remaining == 4'd1) begin
            state_nxt = DONE;
            last_nxt  = gnt[1];
          end
        end
      end

      DONE: begin
        state_nxt    = IDLE;
        gnt_nxt      = 2'b00;
        err_flag_nxt = 1'b0;
      end

      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      gnt       <= 2'b00;
      q         <= 4'd0;
      remaining <= 4'd0;
      err_flag  <= 1'b0;
      last      <= 1'b1;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      q         <= q_nxt;
      remaining <= remaining_nxt;
      err_flag  <= err_flag_nxt;
      last      <= last_nxt;
    end
  end

endmodule

// File: tb/tb_mod12_load_arb.sv
// Directed self-checking bench for mod12_load_arb: reset, runs, wrap, ties,
// illegal load, zero length, abort and mid-run reset.
module tb_mod12_load_arb;

  logic       clk;
  logic       rst;
  logic       req0;
  logic       req1;
  logic [3:0] in0;
  logic [3:0] in1;
  logic [3:0] len0;
  logic [3:0] len1;
  logic [1:0] gnt;
  logic [3:0] q;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  mod12_load_arb dut (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .req1 (req1),
    .in0  (in0),
    .in1  (in1),
    .len0 (len0),
    .len1 (len1),
    .gnt  (gnt),
    .q    (q),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic [3:0] i0, input logic [3:0] l0,
                               input logic r1, input logic [3:0] i1, input logic [3:0] l1);
    req0 = r0; in0 = i0; len0 = l0;
    req1 = r1; in1 = i1; len1 = l1;
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  // Compares the full observable state in one call; each field counts as a comparison.
  task automatic checkAll(input string tag, input int e_gnt, input int e_q,
                          input int e_busy, input int e_done, input int e_err);
    checkOutput({tag, ".gnt"},  int'(gnt),  e_gnt);
    checkOutput({tag, ".q"},    int'(q),    e_q);
    checkOutput({tag, ".busy"}, int'(busy), e_busy);
    checkOutput({tag, ".done"}, int'(done), e_done);
    checkOutput({tag, ".err"},  int'(err),  e_err);
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    #12;
    checkAll("reset", 0, 0, 0, 0, 0);
    rst = 1'b1;
    waitCycle();
    checkAll("idle_after_reset", 0, 0, 0, 0, 0);

    // Basic run: start 3, length 4.
    applyStimulus(1'b1, 4'd3, 4'd4, 1'b0, 4'd0, 4'd0);
    waitCycle();
    checkAll("basic_grant", 1, 0, 1, 0, 0);
    waitCycle();
    checkAll("basic_load", 1, 3, 1, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      waitCycle();
      checkAll("basic_run", 1, 3 + i, 1, 0, 0);
    end
    waitCycle();
    checkAll("basic_done", 1, 7, 1, 1, 0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    waitCycle();
    checkAll("basic_idle", 0, 7, 0, 0, 0);

    // Wrap-around: start 10, length 4 -> 10, 11, 0, 1, 2.
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd10, 4'd4);
    waitCycle();
    checkAll("wrap_grant", 2, 7, 1, 0, 0);
    waitCycle();
    checkAll("wrap_load", 2, 10, 1, 0, 0);
    waitCycle();
    checkAll("wrap_q11", 2, 11, 1, 0, 0);
    waitCycle();
    checkAll("wrap_q0", 2, 0, 1, 0, 0);
    waitCycle();
    checkAll("wrap_q1", 2, 1, 1, 0, 0);
    waitCycle();
    checkAll("wrap_done", 2, 2, 1, 1, 0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    waitCycle();
    checkAll("wrap_idle", 0, 2, 0, 0, 0);

    // Tie held across two transactions; last grant was requester 1, so 0 then 1.
    applyStimulus(1'b1, 4'd2, 4'd1, 1'b1, 4'd7, 4'd1);
    waitCycle();
    checkAll("tie1_grant", 1, 2, 1, 0, 0);
    waitCycle();
    checkAll("tie1_load", 1, 2, 1, 0, 0);
    waitCycle();
    checkAll("tie1_done", 1, 3, 1, 1, 0);
    waitCycle();
    checkAll("tie1_idle", 0, 3, 0, 0, 0);
    waitCycle();
    checkAll("tie2_grant", 2, 3, 1, 0, 0);
    waitCycle();
    checkAll("tie2_load", 2, 7, 1, 0, 0);
    waitCycle();
    checkAll("tie2_done", 2, 8, 1, 1, 0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    waitCycle();
    checkAll("tie2_idle", 0, 8, 0, 0, 0);

    // Illegal load value 13 loads 0 and flags err at done.
    applyStimulus(1'b1, 4'd13, 4'd2, 1'b0, 4'd0, 4'd0);
    waitCycle();
    checkAll("ill_grant", 1, 8, 1, 0, 0);
    waitCycle();
    checkAll("ill_load", 1, 0, 1, 0, 0);
    waitCycle();
    checkAll("ill_run", 1, 1, 1, 0, 0);
    waitCycle();
    checkAll("ill_done", 1, 2, 1, 1, 1);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    waitCycle();
    checkAll("ill_idle", 0, 2, 0, 0, 0);

    // Zero length: done on the cycle right after LOAD, q stays at 5.
    applyStimulus(1'b1, 4'd5, 4'd0, 1'b0, 4'd0, 4'd0);
    waitCycle();
    checkAll("zero_grant", 1, 2, 1, 0, 0);
    waitCycle();
    checkAll("zero_done", 1, 5, 1, 1, 0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    waitCycle();
    checkAll("zero_idle", 0, 5, 0, 0, 0);

    // Abort after two RUN edges: q holds 2, no done.
    applyStimulus(1'b1, 4'd0, 4'd8, 1'b0, 4'd0, 4'd0);
    waitCycle();
    checkAll("abort_grant", 1, 5, 1, 0, 0);
    waitCycle();
    checkAll("abort_load", 1, 0, 1, 0, 0);
    waitCycle();
    waitCycle();
    checkAll("abort_run2", 1, 2, 1, 0, 0);
    applyStimulus(1'b0, 4'd0, 4'd8, 1'b0, 4'd0, 4'd0);
    waitCycle();
    checkAll("abort_idle", 0, 2, 0, 0, 0);

    // Requester 1 aborts; pointer must stay at requester 0 so the next tie goes to 1.
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd4, 4'd5);
    waitCycle();
    checkAll("abort1_grant", 2, 2, 1, 0, 0);
    waitCycle();
    checkAll("abort1_load", 2, 4, 1, 0, 0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd4, 4'd5);
    waitCycle();
    checkAll("abort1_idle", 0, 4, 0, 0, 0);
    applyStimulus(1'b1, 4'd1, 4'd3, 1'b1, 4'd9, 4'd3);
    waitCycle();
    checkAll("ptr_tie_grant", 2, 4, 1, 0, 0);
    waitCycle();
    checkAll("ptr_tie_load", 2, 9, 1, 0, 0);
    waitCycle();
    checkAll("ptr_tie_run", 2, 10, 1, 0, 0);

    // Reset mid-run clears everything at once and restores the pointer.
    #2;
    rst = 1'b0;
    #1;
    checkAll("midrun_reset", 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    waitCycle();
    checkAll("post_reset_grant", 1, 0, 1, 0, 0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    waitCycle();
    checkAll("final_idle", 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod12_load_arb.md
MOD12_LOAD_ARB -- requirements
Module: mod12_load_arb

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port req0  input  1  requester 0 asks for use of the shared mod-12 counter.
REQ-004 SHALL have port req1  input  1  requester 1 asks for use of the shared mod-12 counter.
REQ-005 SHALL have port in0  input  4  requester 0 start (load) value.
REQ-006 SHALL have port in1  input  4  requester 1 start (load) value.
REQ-007 SHALL have port len0  input  4  requester 0 run length, in count cycles (0..15).
REQ-008 SHALL have port len1  input  4  requester 1 run length, in count cycles (0..15).
REQ-009 SHALL have port gnt  output  2  one-hot grant: bit0 = requester 0, bit1 = requester 1; registered.
REQ-010 SHALL have port q  output  4  shared counter value, always in 0..11.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-012 SHALL have port done  output  1  high for exactly one cycle, in DONE state.
REQ-013 SHALL have port err  output  1  valid with done; high if the granted load value was illegal (>11).

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, RUN, DONE; no other reachable states.
REQ-015 IDLE: no req -> stay. Any req -> at that edge latch winner, gnt = winner one-hot, state -> LOAD.
REQ-016 Arbitration SHALL be round-robin: if only one req is high, it wins; if both are high, the requester not granted last wins.
REQ-017 The last-granted pointer SHALL update on entry to DONE, not on abort.
REQ-018 LOAD, one cycle: q <= winner's in if in <= 11, else q <= 0 and err flag set; remaining <= winner's len.
REQ-019 LOAD SHALL sample in/len at the LOAD edge; requester holds in/len stable from req until that edge.
REQ-020 LOAD -> RUN if len != 0; LOAD -> DONE if len == 0, so q stays at the loaded value.
REQ-021 RUN, each edge: q <= (q == 11) ? 0 : q + 1; remaining <= remaining - 1; on the edge where remaining == 1 -> DONE.
REQ-022 A run of length L SHALL produce exactly L increments after the load; the final q equals (start + L) mod 12.
REQ-023 DONE, one cycle: done = 1, err = latched flag, gnt held; next edge -> IDLE, gnt = 00, done = 0, err cleared.
REQ-024 q SHALL hold its value in IDLE and DONE; q is only written in LOAD and RUN.
REQ-025 Abort: if the granted req drops during LOAD or RUN, next edge -> IDLE, gnt = 00, q holds, done not asserted, pointer unchanged.
REQ-026 A req arriving at the other port while busy SHALL be ignored until IDLE; earliest re-grant is the edge after DONE's successor IDLE cycle.
REQ-027 Latency, req high in IDLE at edge n: gnt at n, q = start at n+1, done during the cycle after edge n+1+L.
REQ-028 gnt SHALL never be 11; gnt != 00 exactly when state is LOAD, RUN or DONE.

Reset
REQ-029 rst low SHALL immediately force state IDLE, q = 0, gnt = 00, busy = 0, done = 0, err = 0, remaining = 0, pointer = requester 1, so requester 0 wins the first tie.
REQ-030 Reset asserted mid-RUN SHALL abort without a done pulse; after release, the FSM resumes arbitration from IDLE on the first edge.

Verification
REQ-031 Reset scenario: rst = 0 -> q = 0, gnt = 00, busy = 0, done = 0.
REQ-032 Basic run: req0 = 1, in0 = 3, len0 = 4 -> gnt = 01; q = 3, 4, 5, 6, 7; one done pulse with err = 0; then gnt = 00.
REQ-033 Wrap-around: req1 = 1, in1 = 10, len1 = 4 -> q = 10, 11, 0, 1, 2; done with err = 0.
REQ-034 Simultaneous requests: req0 = req1 = 1 held for two transactions (len = 1 each) -> gnt = 01, then 10.
REQ-035 Illegal load and zero length: in0 = 13, len0 = 2 -> q = 0, 1, 2 with err = 1 at done; in0 = 5, len0 = 0 -> q = 5 and done on the cycle after LOAD.
REQ-036 Abort: req0 dropped after 2 RUN edges (in0 = 0, len0 = 8) -> q holds 2, no done, gnt = 00; reset pulse mid-RUN -> q = 0 at once.
